// File: rtl/dm_cache_datapath.sv
// Direct-mapped cache datapath: address generator, tag/valid/data stores, block
// fetch buffer and hit counter. Define DM_MISS_COUNT_EN to add the missCount output.
module dm_cache_datapath #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int INDEX_W      = 10,
  parameter int OFFSET_W     = 2,
  parameter int START_ADDR   = 1024,
  parameter int ACCESS_COUNT = 8192,
  parameter int COUNT_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             checkHit,
  input  logic                             readCache,
  input  logic                             writeCache,
  input  logic                             readMem,
  input  logic                             hitCountEn,
  input  logic                             addressInc,
  input  logic [DATA_W*(2**OFFSET_W)-1:0]  memData,
  output logic [ADDR_W-1:0]                memAddr,
  output logic                             hit,
  output logic [DATA_W-1:0]                dataOut,
  output logic [ADDR_W-1:0]                addr,
  output logic [COUNT_W-1:0]               hitCount,
  output logic                             done
`ifdef DM_MISS_COUNT_EN
  ,
  output logic [COUNT_W-1:0]               missCount
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 2 ** INDEX_W;
  localparam int WPB   = 2 ** OFFSET_W;
  localparam int ACC_W = $clog2(ACCESS_COUNT + 1);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(START_ADDR - 1);

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;

  // Data and tag arrays carry no reset; the valid vector alone qualifies them.
  logic [WPB-1:0][DATA_W-1:0] data_arr [LINES];
  logic [TAG_W-1:0]           tag_arr  [LINES];

  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [ACC_W-1:0]           acc_cnt_q, acc_cnt_d;
  logic                       done_q, done_d;
  logic                       hit_q, hit_d;
  logic [DATA_W-1:0]          data_out_q, data_out_d;
  logic [COUNT_W-1:0]         hit_count_q, hit_count_d;
  logic [LINES-1:0]           valid_q, valid_d;
  logic [WPB-1:0][DATA_W-1:0] line_buf_q, line_buf_d;

  assign offset  = addr_q[OFFSET_W-1:0];
  assign index   = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag     = addr_q[ADDR_W-1:OFFSET_W+INDEX_W];
  assign memAddr = {tag, index, {OFFSET_W{1'b0}}};

  always_comb begin
    addr_d      = addr_q;
    acc_cnt_d   = acc_cnt_q;
    done_d      = done_q;
    hit_d       = hit_q;
    data_out_d  = data_out_q;
    hit_count_d = hit_count_q;
    valid_d     = valid_q;
    line_buf_d  = line_buf_q;
    if (rst) begin
      addr_d      = RESET_ADDR;
      acc_cnt_d   = '0;
      done_d      = 1'b0;
      hit_d       = 1'b0;
      data_out_d  = '0;
      hit_count_d = '0;
      valid_d     = '0;
      line_buf_d  = '0;
    end else begin
      if (addressInc && !done_q) begin
        addr_d    = addr_q + 1'b1;
        acc_cnt_d = acc_cnt_q + 1'b1;
        done_d    = (acc_cnt_q == ACC_W'(ACCESS_COUNT - 1));
      end
      if (checkHit)
        hit_d = valid_q[index] && (tag_arr[index] == tag);
      // Reads the array before this edge's write lands, so a same-cycle
      // writeCache returns the old block.
      if (readCache)
        data_out_d = data_arr[index][offset];
      if (readMem)
        line_buf_d = memData;
      if (writeCache)
        valid_d[index] = 1'b1;
      if (hitCountEn && (hit_count_q != {COUNT_W{1'b1}}))
        hit_count_d = hit_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    addr_q      <= addr_d;
    acc_cnt_q   <= acc_cnt_d;
    done_q      <= done_d;
    hit_q       <= hit_d;
    data_out_q  <= data_out_d;
    hit_count_q <= hit_count_d;
    valid_q     <= valid_d;
    line_buf_q  <= line_buf_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && writeCache) begin
      data_arr[index] <= line_buf_q;
      tag_arr[index]  <= tag;
    end
  end

`ifdef DM_MISS_COUNT_EN
  logic [COUNT_W-1:0] miss_count_q, miss_count_d;

  always_comb begin
    miss_count_d = miss_count_q;
    if (rst)
      miss_count_d = '0;
    else if (readMem && (miss_count_q != {COUNT_W{1'b1}}))
      miss_count_d = miss_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    miss_count_q <= miss_count_d;
  end

  assign missCount = miss_count_q;
`endif

  assign addr     = addr_q;
  assign done     = done_q;
  assign hit      = hit_q;
  assign dataOut  = data_out_q;
  assign hitCount = hit_count_q;

endmodule

// File: tb/tb_dm_cache_datapath.sv
// Directed bench for dm_cache_datapath: a vector table for reset/fill/hit, then
// hand sequences for conflict eviction, completion and mid-run reset.
module tb_dm_cache_datapath;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         checkHit = 1'b0, readCache = 1'b0, writeCache = 1'b0;
  logic         readMem = 1'b0, hitCountEn = 1'b0, addressInc = 1'b0;
  logic [127:0] memData = '0;
  logic [14:0]  memAddr;
  logic         hit;
  logic [31:0]  dataOut;
  logic [14:0]  addr;
  logic [15:0]  hitCount;
  logic         done;
`ifdef DM_MISS_COUNT_EN
  logic [15:0]  missCount;
`endif

  int total  = 0;
  int passed = 0;

  localparam logic [127:0] BLK_A = 128'hA000_0003_A000_0002_A000_0001_A000_0000;
  localparam logic [127:0] BLK_B = 128'hB000_0003_B000_0002_B000_0001_B000_0000;

  // Strobe vector order: {checkHit, readCache, writeCache, readMem, hitCountEn, addressInc}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_CHK  = 6'b100000;
  localparam logic [5:0] S_RDC  = 6'b010000;
  localparam logic [5:0] S_WRC  = 6'b001000;
  localparam logic [5:0] S_RDM  = 6'b000100;
  localparam logic [5:0] S_HCE  = 6'b000010;
  localparam logic [5:0] S_INC  = 6'b000001;

  dm_cache_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .checkHit   (checkHit),
    .readCache  (readCache),
    .writeCache (writeCache),
    .readMem    (readMem),
    .hitCountEn (hitCountEn),
    .addressInc (addressInc),
    .memData    (memData),
    .memAddr    (memAddr),
    .hit        (hit),
    .dataOut    (dataOut),
    .addr       (addr),
    .hitCount   (hitCount),
    .done       (done)
`ifdef DM_MISS_COUNT_EN
    ,
    .missCount  (missCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   strb;
    logic [127:0] mem;
    logic         exp_hit;
    logic [31:0]  exp_dout;
    logic [14:0]  exp_addr;
    logic [15:0]  exp_hc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  // Drive strobes for one clock edge, then sample 1ns after that edge.
  task automatic apply(input logic [5:0] s, input logic [127:0] m);
    {checkHit, readCache, writeCache, readMem, hitCountEn, addressInc} = s;
    memData = m;
    @(posedge clk);
    #1;
    {checkHit, readCache, writeCache, readMem, hitCountEn, addressInc} = S_NONE;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(S_NONE, '0);
    rst = 1'b0;
  endtask

  task automatic inc_n(input int n);
    for (int k = 0; k < n; k++) apply(S_INC, '0);
  endtask

  initial begin
    vecs[0] = '{S_CHK,         '0,    1'b0, 32'h0,         15'd1023, 16'd0};
    vecs[1] = '{S_INC,         '0,    1'b0, 32'h0,         15'd1024, 16'd0};
    vecs[2] = '{S_CHK,         '0,    1'b0, 32'h0,         15'd1024, 16'd0};
    vecs[3] = '{S_RDM,         BLK_A, 1'b0, 32'h0,         15'd1024, 16'd0};
    vecs[4] = '{S_WRC,         '0,    1'b0, 32'h0,         15'd1024, 16'd0};
    vecs[5] = '{S_RDC,         '0,    1'b0, 32'hA000_0000, 15'd1024, 16'd0};
    vecs[6] = '{S_INC,         '0,    1'b0, 32'hA000_0000, 15'd1025, 16'd0};
    vecs[7] = '{S_CHK,         '0,    1'b1, 32'hA000_0000, 15'd1025, 16'd0};
    vecs[8] = '{S_RDC | S_HCE, '0,    1'b1, 32'hA000_0001, 15'd1025, 16'd1};

    // Reset state
    do_reset();
    chk("rst_addr", addr, 15'd1023);
    chk("rst_hit", hit, 1'b0);
    chk("rst_hitcount", hitCount, 16'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_dataout", dataOut, 32'h0);
`ifdef DM_MISS_COUNT_EN
    chk("rst_misscount", missCount, 16'd0);
`endif

    // Cold miss, fill, spatial hit
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].strb, vecs[i].mem);
      chk($sformatf("v%0d_hit", i), hit, vecs[i].exp_hit);
      chk($sformatf("v%0d_dout", i), dataOut, vecs[i].exp_dout);
      chk($sformatf("v%0d_addr", i), addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_memaddr", i), memAddr, vecs[i].exp_addr & 15'h7FFC);
      chk($sformatf("v%0d_hitcount", i), hitCount, vecs[i].exp_hc);
    end
`ifdef DM_MISS_COUNT_EN
    chk("fill_misscount", missCount, 16'd1);
`endif

    // Conflict: 5120 shares index 256 with 1024 but carries tag 1
    inc_n(4095);
    chk("conf_addr", addr, 15'd5120);
    chk("conf_memaddr", memAddr, 15'd5120);
    chk("conf_done", done, 1'b0);
    apply(S_CHK, '0);
    chk("conf_hit", hit, 1'b0);
    apply(S_RDM, BLK_B);
    apply(S_RDC | S_WRC, '0);
    chk("conf_prewrite_dout", dataOut, 32'hA000_0000);
    apply(S_RDC, '0);
    chk("conf_new_dout", dataOut, 32'hB000_0000);
    apply(S_CHK, '0);
    chk("conf_refill_hit", hit, 1'b1);
    inc_n(3);
    apply(S_RDC, '0);
    chk("conf_word3_dout", dataOut, 32'hB000_0003);
    chk("conf_word3_memaddr", memAddr, 15'd5120);

    // Completion after ACCESS_COUNT increments
    do_reset();
    inc_n(8191);
    chk("cmp_done_early", done, 1'b0);
    chk("cmp_addr_early", addr, 15'd9214);
    apply(S_INC, '0);
    chk("cmp_done", done, 1'b1);
    chk("cmp_addr", addr, 15'd9215);
    apply(S_INC, '0);
    chk("cmp_addr_hold", addr, 15'd9215);
    chk("cmp_done_hold", done, 1'b1);

    // Mid-run reset takes priority over same-edge strobes
    do_reset();
    chk("mid_done_cleared", done, 1'b0);
    apply(S_INC, '0);
    apply(S_RDM, BLK_A);
    apply(S_WRC, '0);
    apply(S_CHK, '0);
    chk("mid_hit_before", hit, 1'b1);
    for (int k = 0; k < 5; k++) apply(S_HCE, '0);
    chk("mid_hitcount5", hitCount, 16'd5);
    rst = 1'b1;
    apply(S_HCE | S_WRC, '0);
    rst = 1'b0;
    chk("mid_rst_hitcount", hitCount, 16'd0);
    chk("mid_rst_addr", addr, 15'd1023);
    chk("mid_rst_hit", hit, 1'b0);
`ifdef DM_MISS_COUNT_EN
    chk("mid_rst_misscount", missCount, 16'd0);
`endif
    apply(S_INC, '0);
    apply(S_CHK, '0);
    chk("mid_invalidated_hit", hit, 1'b0);
    chk("mid_addr_after", addr, 15'd1024);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
